// File: rtl/qracc_pkg.sv
// Shared types for the partial-sum requantization stage.
package qracc_pkg;

    localparam int CFG_TILES_W = 4;
    localparam int SHIFT_W     = 5;

    // Per-output configuration, captured when the first tile of an output arrives
    typedef struct packed {
        logic [CFG_TILES_W-1:0] num_tiles_m1;
        logic [SHIFT_W-1:0]     shift;
        logic                   relu_en;
    } psum_cfg_t;

endpackage

// File: rtl/psum_out_fifo.sv
// Small synchronous FIFO holding finished output vectors.
// Push while full is accepted only when a pop happens on the same edge.
module psum_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [AW-1:0]               r_wr;
    logic [AW-1:0]               r_rd;
    logic [AW:0]                 r_cnt;
    logic                        w_pop;
    logic                        w_push;

    assign full_o  = (r_cnt == (AW+1)'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign count_o = r_cnt;
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    // Head reads as zero while empty so stale entries never show on the bus
    assign rdata_o = empty_o ? '0 : r_mem[r_rd];

    // Storage, pointers and occupancy; clear empties without touching storage
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mem <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (clear_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= wdata_i;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/psum_requant.sv
// Accumulates MAC partial sums over several tiles, requantizes the total
// (rounding shift, optional ReLU, saturation) and queues finished vectors.
module psum_requant
    import qracc_pkg::*;
#(
    parameter int inBits       = 8,
    parameter int numElements  = 32,
    parameter int accBits      = 16,
    parameter int outBits      = 8,
    parameter int maxTilesBits = 4,
    parameter int fifoDepth    = 2
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [maxTilesBits-1:0]       num_tiles_m1_i,
    input  logic [4:0]                    shift_i,
    input  logic                          relu_en_i,
    input  logic                          clear_i,
    input  logic [numElements*inBits-1:0] psum_data_i,
    input  logic                          psum_valid_i,
    output logic                          psum_ready_o,
    output logic [numElements*outBits-1:0] out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          busy_o,
    output logic                          overflow_o
);

    localparam logic signed [accBits:0] Q_MAX = (accBits+1)'((2**(outBits-1)) - 1);
    localparam logic signed [accBits:0] Q_MIN = (accBits+1)'(-(2**(outBits-1)));

    logic [numElements-1:0][accBits-1:0] r_acc;
    logic [numElements-1:0][accBits-1:0] w_acc_nxt;
    logic [numElements-1:0][outBits-1:0] w_req;
    logic [numElements-1:0]              w_lane_ovf;
    logic [maxTilesBits-1:0]             r_tile_cnt;
    logic                                r_pending;
    logic                                r_ovf;
    psum_cfg_t                           r_cfg;
    psum_cfg_t                           w_cfg_in;
    logic                                w_first;
    logic                                w_last;
    logic [maxTilesBits-1:0]             w_last_m1;
    logic                                w_accept;
    logic                                w_push;
    logic                                w_fifo_full;
    logic                                w_fifo_empty;
    logic [$clog2(fifoDepth):0]          w_fifo_cnt;

    assign w_cfg_in = '{num_tiles_m1: CFG_TILES_W'(num_tiles_m1_i),
                        shift:        shift_i,
                        relu_en:      relu_en_i};

    assign w_first   = (r_tile_cnt == '0);
    // The first tile decides the tile count from the live input, later tiles from the latched copy
    assign w_last_m1 = w_first ? num_tiles_m1_i : maxTilesBits'(r_cfg.num_tiles_m1);
    assign w_last    = (r_tile_cnt == w_last_m1);

    assign psum_ready_o = !(r_pending && w_fifo_full);
    assign w_accept     = psum_valid_i && psum_ready_o && !clear_i;
    // Full FIFO still takes the result when the head leaves on the same edge
    assign w_push       = r_pending && (!w_fifo_full || out_ready_i);

    assign out_valid_o = !w_fifo_empty;
    assign busy_o      = !w_first || r_pending;
    assign overflow_o  = r_ovf;

    for (genvar g = 0; g < numElements; g++) begin : g_lane
        logic signed [inBits-1:0]  w_p;
        logic signed [accBits-1:0] w_a;
        logic signed [accBits:0]   w_ext;
        logic signed [accBits:0]   w_sum;
        logic signed [accBits:0]   w_rnd;
        logic signed [accBits:0]   w_r;
        logic signed [accBits:0]   w_rl;
        logic                      w_ovf;

        assign w_p   = psum_data_i[g*inBits +: inBits];
        assign w_a   = r_acc[g];
        assign w_ext = {w_a[accBits-1], w_a};
        assign w_sum = w_ext + {{(accBits+1-inBits){w_p[inBits-1]}}, w_p};
        // One guard bit: the sum left the accumulator range iff the top two bits differ
        assign w_ovf = w_sum[accBits] ^ w_sum[accBits-1];

        assign w_lane_ovf[g] = !w_first && w_ovf;
        assign w_acc_nxt[g]  = w_first ? {{(accBits-inBits){w_p[inBits-1]}}, w_p}
                             : w_ovf   ? {w_sum[accBits], {(accBits-1){~w_sum[accBits]}}}
                             :           w_sum[accBits-1:0];

        // Round half up, then arithmetic shift, in accBits+1 bits
        assign w_rnd = (r_cfg.shift == '0) ? '0
                     : ((accBits+1)'(1) <<< (r_cfg.shift - 5'd1));
        assign w_r   = (w_ext + w_rnd) >>> r_cfg.shift;
        assign w_rl  = (r_cfg.relu_en && w_r[accBits]) ? '0 : w_r;
        assign w_req[g] = (w_rl > Q_MAX) ? Q_MAX[outBits-1:0]
                        : (w_rl < Q_MIN) ? Q_MIN[outBits-1:0]
                        :                  w_rl[outBits-1:0];
    end

    // Accumulator, tile counter, config latch, pending flag and sticky overflow
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc      <= '0;
            r_tile_cnt <= '0;
            r_pending  <= 1'b0;
            r_ovf      <= 1'b0;
            r_cfg      <= '0;
        end else if (clear_i) begin
            r_tile_cnt <= '0;
            r_pending  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc      <= w_acc_nxt;
                r_tile_cnt <= w_last ? '0 : r_tile_cnt + 1'b1;
                if (w_first) r_cfg <= w_cfg_in;
                if (|w_lane_ovf) r_ovf <= 1'b1;
            end
            // A final tile arriving on the finalize edge re-arms pending for the next vector
            if (w_accept && w_last) r_pending <= 1'b1;
            else if (w_push)        r_pending <= 1'b0;
        end
    end

    // Occupancy and empty flag must always agree
    always_comb assert (w_fifo_empty == (w_fifo_cnt == '0));

    psum_out_fifo #(
        .WIDTH (numElements*outBits),
        .DEPTH (fifoDepth)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .clear_i (clear_i),
        .push_i  (w_push),
        .wdata_i (w_req),
        .pop_i   (out_ready_i),
        .rdata_o (out_data_o),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_cnt)
    );

endmodule
